// File: rtl/decode_pkg.sv
// Shared definitions for the 16-bit core decode stage: widths, opcodes, ALU codes,
// instruction field positions and the immediate sign-extension helper.
package decode_pkg;

    localparam int XLEN  = 16;
    localparam int NREGS = 16;

    localparam int OPC_LSB   = 0;
    localparam int RD_LSB    = 3;
    localparam int RS1_LSB   = 6;
    localparam int RS2_LSB   = 9;
    localparam int FUNCT_LSB = 12;
    localparam int IMM_LSB   = 9;

    typedef enum logic [2:0] {
        OP_R   = 3'b000,
        OP_I   = 3'b001,
        OP_LD  = 3'b010,
        OP_ST  = 3'b011,
        OP_BEQ = 3'b100,
        OP_BNE = 3'b101,
        OP_BLT = 3'b110,
        OP_J   = 3'b111
    } opcode_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    function automatic logic [XLEN-1:0] sext_imm7(input logic [6:0] imm7);
        return {{(XLEN-7){imm7[6]}}, imm7};
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 16x16 register file: one write port, three 3-bit-addressed read ports, x0 reads zero.
// Same-cycle write-to-read forwarding is added when RF_BYPASS_EN is defined.
module decode_regfile
    import decode_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [3:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [2:0]      raddr1,
    input  logic [2:0]      raddr2,
    input  logic [2:0]      raddr3,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] rdata3
);

    logic [XLEN-1:0] regs_r  [NREGS];
    logic [2:0]      raddr_s [3];
    logic [XLEN-1:0] rdata_s [3];

    assign raddr_s[0] = raddr1;
    assign raddr_s[1] = raddr2;
    assign raddr_s[2] = raddr3;
    assign rdata1     = rdata_s[0];
    assign rdata2     = rdata_s[1];
    assign rdata3     = rdata_s[2];

    // Storage update; entry 0 is never written so it stays at its reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (we && (waddr != 4'd0)) begin
            regs_r[waddr] <= wdata;
        end else begin
            regs_r <= regs_r;
        end
    end

    // Read ports: zero-extended address, hard-wired zero for x0.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rdata_s[p] = {XLEN{1'b0}};
            if (raddr_s[p] == 3'd0) begin
                rdata_s[p] = {XLEN{1'b0}};
`ifdef RF_BYPASS_EN
            end else if (we && (waddr == {1'b0, raddr_s[p]})) begin
                rdata_s[p] = wdata;
`endif
            end else begin
                rdata_s[p] = regs_r[{1'b0, raddr_s[p]}];
            end
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction-decode stage: control decode, operand read, immediate and early branch resolve.
// Optional macro RF_BYPASS_EN enables same-cycle register-file write forwarding.
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IPCP2,
    input  logic [15:0] pc_in,
    input  logic [15:0] ir_in,
    input  logic [3:0]  loadAddr,
    input  logic [15:0] loadData,
    input  logic        rf_write,
    input  logic        comparatorMux1Control,
    input  logic        comparatorMux2Control,
    input  logic [15:0] comparatorMuxForward,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [2:0]  ALUOp,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        RegStore,
    output logic [15:0] OPCP2,
    output logic [15:0] Arg1,
    output logic [15:0] Arg2,
    output logic [15:0] Arg3,
    output logic [15:0] Imm,
    output logic [2:0]  Rs1,
    output logic [2:0]  Rs2,
    output logic [2:0]  Rd,
    output logic [15:0] new_pc,
    output logic        jump
);

    opcode_t         opcode_s;
    logic [2:0]      funct_s;
    logic [2:0]      rd_s;
    logic [2:0]      rs1_s;
    logic [2:0]      rs2_s;
    logic [XLEN-1:0] rf1_s;
    logic [XLEN-1:0] rf2_s;
    logic [XLEN-1:0] rf3_s;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] cmp_a_s;
    logic [XLEN-1:0] cmp_b_s;
    logic            taken_s;

    assign opcode_s = opcode_t'(ir_in[OPC_LSB +: 3]);
    assign funct_s  = ir_in[FUNCT_LSB +: 3];
    assign rd_s     = ir_in[RD_LSB +: 3];
    assign rs1_s    = ir_in[RS1_LSB +: 3];
    assign rs2_s    = ir_in[RS2_LSB +: 3];
    assign imm_s    = sext_imm7(ir_in[IMM_LSB +: 7]);

    decode_regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_write),
        .waddr  (loadAddr),
        .wdata  (loadData),
        .raddr1 (rs1_s),
        .raddr2 (rs2_s),
        .raddr3 (rd_s),
        .rdata1 (rf1_s),
        .rdata2 (rf2_s),
        .rdata3 (rf3_s)
    );

    assign OPCP2 = IPCP2;
    assign Arg1  = rf1_s;
    assign Arg2  = rf2_s;
    assign Arg3  = rf3_s;
    assign Imm   = imm_s;
    assign Rs1   = rs1_s;
    assign Rs2   = rs2_s;
    assign Rd    = rd_s;

    // Comparator B reads the rd field so a branch compares rs1 against ir[5:3].
    assign cmp_a_s = comparatorMux1Control ? rf1_s : comparatorMuxForward;
    assign cmp_b_s = comparatorMux2Control ? rf3_s : comparatorMuxForward;
    assign new_pc  = pc_in + {imm_s[XLEN-2:0], 1'b0};

    // Control decode with reset override on the side-effecting enables.
    always_comb begin
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = ALU_ADD;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        RegStore = 1'b0;
        case (opcode_s)
            OP_R: begin
                RegWrite = 1'b1;
                ALUSrc   = 1'b1;
                ALUOp    = funct_s;
                RegStore = 1'b1;
            end
            OP_I: begin
                RegWrite = 1'b1;
                RegStore = 1'b1;
            end
            OP_LD: begin
                RegWrite = 1'b1;
                MemRead  = 1'b1;
            end
            OP_ST: begin
                MemWrite = 1'b1;
            end
            default: begin
                RegWrite = 1'b0;
            end
        endcase
        if (reset) begin
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemRead  = 1'b0;
        end else begin
            RegStore = RegStore;
        end
    end

    // Early branch resolution; jump is active-low "take new_pc".
    always_comb begin
        taken_s = 1'b0;
        case (opcode_s)
            OP_BEQ:  taken_s = (cmp_a_s == cmp_b_s);
            OP_BNE:  taken_s = (cmp_a_s != cmp_b_s);
            OP_BLT:  taken_s = ($signed(cmp_a_s) < $signed(cmp_b_s));
            OP_J:    taken_s = 1'b1;
            default: taken_s = 1'b0;
        endcase
        if (reset) begin
            jump = 1'b1;
        end else begin
            jump = ~taken_s;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized checks
// against a field-arithmetic reference model of the register file and decoder.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] IPCP2, pc_in, ir_in;
    logic [3:0]  loadAddr;
    logic [15:0] loadData;
    logic        rf_write;
    logic        comparatorMux1Control, comparatorMux2Control;
    logic [15:0] comparatorMuxForward;
    logic        RegWrite, ALUSrc, MemWrite, MemRead, RegStore, jump;
    logic [2:0]  ALUOp, Rs1, Rs2, Rd;
    logic [15:0] OPCP2, Arg1, Arg2, Arg3, Imm, new_pc;

    int n_cmp = 0;
    int n_err = 0;
    int model_rf [16];

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .reset(reset), .IPCP2(IPCP2), .pc_in(pc_in), .ir_in(ir_in),
        .loadAddr(loadAddr), .loadData(loadData), .rf_write(rf_write),
        .comparatorMux1Control(comparatorMux1Control),
        .comparatorMux2Control(comparatorMux2Control),
        .comparatorMuxForward(comparatorMuxForward),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemWrite(MemWrite),
        .MemRead(MemRead), .RegStore(RegStore), .OPCP2(OPCP2), .Arg1(Arg1),
        .Arg2(Arg2), .Arg3(Arg3), .Imm(Imm), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
        .new_pc(new_pc), .jump(jump)
    );

    function automatic int ref_read(int a);
        if (a == 0) return 0;
`ifdef RF_BYPASS_EN
        if (rf_write && (int'(loadAddr) == a)) return int'(loadData);
`endif
        return model_rf[a];
    endfunction

    // Clock edge with model commit of any pending write.
    task automatic step();
        @(posedge clk);
        if (rf_write && loadAddr != 4'd0 && !reset) model_rf[loadAddr] = int'(loadData);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; rf_write = 1'b0; loadAddr = 4'd0; loadData = 16'h0000;
        IPCP2 = 16'h0000; pc_in = 16'h0000; comparatorMuxForward = 16'h0000;
        comparatorMux1Control = 1'b1; comparatorMux2Control = 1'b1;
        for (int i = 0; i < 16; i++) model_rf[i] = 0;
        ir_in = 16'h1562;
        #3;
        n_cmp++;
        if ({RegWrite, MemRead} !== 2'b00) begin
            n_err++; $display("FAIL reset_load_ctrl: got RegWrite=%0b MemRead=%0b want 0 0", RegWrite, MemRead);
        end
        ir_in = 16'h1563;
        #1;
        n_cmp++;
        if (MemWrite !== 1'b0) begin
            n_err++; $display("FAIL reset_store_memwrite: got %0b want 0", MemWrite);
        end
        ir_in = 16'h0007;
        #1;
        n_cmp++;
        if (jump !== 1'b1) begin
            n_err++; $display("FAIL reset_jump: got %0b want 1", jump);
        end
        ir_in = 16'h1D60;
        #1;
        n_cmp++;
        if ({Arg1, Arg2, Arg3} !== 48'h0) begin
            n_err++; $display("FAIL reset_rf_clear: got %h %h %h want 0 0 0", Arg1, Arg2, Arg3);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_rf_write();
        rf_write = 1'b1;
        loadAddr = 4'd5; loadData = 16'd16;     step();
        loadAddr = 4'd6; loadData = 16'd10;     step();
        loadAddr = 4'd4; loadData = 16'hFFF8;   step();
        rf_write = 1'b0; loadAddr = 4'd0;
        ir_in = 16'h1D60;
        #1;
        n_cmp++;
        if ({Arg1, Arg2, Arg3} !== {16'd16, 16'd10, 16'hFFF8}) begin
            n_err++; $display("FAIL rf_write_store: got %h %h %h want 0010 000a fff8", Arg1, Arg2, Arg3);
        end
    endtask

    task automatic test_rtype();
        ir_in = 16'h1D60; IPCP2 = 16'd4; pc_in = 16'd2;
        comparatorMux1Control = 1'b1; comparatorMux2Control = 1'b1;
        #1;
        n_cmp++;
        if ({RegWrite, ALUSrc, ALUOp, MemWrite, MemRead, RegStore} !== 8'b1_1_001_0_0_1) begin
            n_err++; $display("FAIL rtype_ctrl: got %b%b%b%b%b%b want 11001001", RegWrite, ALUSrc, ALUOp, MemWrite, MemRead, RegStore);
        end
        n_cmp++;
        if ({Rs1, Rs2, Rd} !== {3'd5, 3'd6, 3'd4}) begin
            n_err++; $display("FAIL rtype_fields: got rs1=%0d rs2=%0d rd=%0d want 5 6 4", Rs1, Rs2, Rd);
        end
        n_cmp++;
        if ({OPCP2, jump} !== {16'd4, 1'b1}) begin
            n_err++; $display("FAIL rtype_pc: got OPCP2=%h jump=%0b want 0004 1", OPCP2, jump);
        end
    endtask

    task automatic test_itype_mem();
        ir_in = 16'h1961;
        #1;
        n_cmp++;
        if ({RegWrite, ALUSrc, ALUOp, RegStore, Imm, jump} !== {1'b1, 1'b0, 3'b000, 1'b1, 16'd12, 1'b1}) begin
            n_err++; $display("FAIL itype: got RW=%0b src=%0b op=%b rs=%0b imm=%h j=%0b want 1 0 000 1 000c 1", RegWrite, ALUSrc, ALUOp, RegStore, Imm, jump);
        end
        ir_in = 16'h1562;
        #1;
        n_cmp++;
        if ({MemRead, RegStore, Imm, RegWrite, MemWrite} !== {1'b1, 1'b0, 16'd10, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL load: got MR=%0b rs=%0b imm=%h RW=%0b MW=%0b want 1 0 000a 1 0", MemRead, RegStore, Imm, RegWrite, MemWrite);
        end
        ir_in = 16'h1563;
        #1;
        n_cmp++;
        if ({MemWrite, RegWrite, MemRead, Arg3} !== {1'b1, 1'b0, 1'b0, 16'hFFF8}) begin
            n_err++; $display("FAIL store: got MW=%0b RW=%0b MR=%0b arg3=%h want 1 0 0 fff8", MemWrite, RegWrite, MemRead, Arg3);
        end
    endtask

    task automatic test_branch();
        ir_in = 16'hFD6C; pc_in = 16'd2;
        comparatorMux1Control = 1'b1; comparatorMux2Control = 1'b1;
        #1;
        n_cmp++;
        if ({jump, new_pc, Imm} !== {1'b0, 16'hFFFE, 16'hFFFE}) begin
            n_err++; $display("FAIL beq_taken: got jump=%0b new_pc=%h imm=%h want 0 fffe fffe", jump, new_pc, Imm);
        end
        comparatorMux2Control = 1'b0; comparatorMuxForward = 16'd17;
        #1;
        n_cmp++;
        if (jump !== 1'b1) begin
            n_err++; $display("FAIL beq_fwd_not_taken: got %0b want 1", jump);
        end
        // blt x4(-8) < forward(10) is true only under signed comparison
        ir_in = 16'h0126; comparatorMuxForward = 16'd10;
        #1;
        n_cmp++;
        if (jump !== 1'b0) begin
            n_err++; $display("FAIL blt_signed: got %0b want 0", jump);
        end
    endtask

    task automatic test_same_addr_and_x0();
        logic [15:0] exp_v;
        ir_in = 16'hFD6C; comparatorMux1Control = 1'b1; comparatorMux2Control = 1'b0;
        comparatorMuxForward = 16'h1234;
        rf_write = 1'b1; loadAddr = 4'd5; loadData = 16'h1234;
        #1;
`ifdef RF_BYPASS_EN
        exp_v = 16'h1234;
`else
        exp_v = 16'd16;
`endif
        n_cmp++;
        if ({Arg1, Arg3, jump} !== {exp_v, exp_v, (exp_v != 16'h1234)}) begin
            n_err++; $display("FAIL same_addr_read: got arg1=%h arg3=%h jump=%0b want %h %h %0b", Arg1, Arg3, jump, exp_v, exp_v, (exp_v != 16'h1234));
        end
        step();
        rf_write = 1'b0;
        #1;
        n_cmp++;
        if (Arg1 !== 16'h1234) begin
            n_err++; $display("FAIL after_write_read: got %h want 1234", Arg1);
        end
        ir_in = 16'h0000; rf_write = 1'b1; loadAddr = 4'd0; loadData = 16'hBEEF;
        #1;
        n_cmp++;
        if ({Arg1, Arg2, Arg3} !== 48'h0) begin
            n_err++; $display("FAIL x0_same_cycle: got %h %h %h want 0 0 0", Arg1, Arg2, Arg3);
        end
        step();
        rf_write = 1'b0;
        #1;
        n_cmp++;
        if ({Arg1, Arg2, Arg3} !== 48'h0) begin
            n_err++; $display("FAIL x0_after_write: got %h %h %h want 0 0 0", Arg1, Arg2, Arg3);
        end
    endtask

    task automatic test_random();
        int op, rdf, r1, r2, fn, imm7, simm, a, b, sa, sb;
        logic taken;
        logic [7:0]  exp_ctrl;
        logic [15:0] exp_pc, exp_imm;
        for (int it = 0; it < 300; it++) begin
            ir_in = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ir_in[5:3] = ir_in[8:6];
            pc_in = 16'($urandom); IPCP2 = 16'($urandom);
            comparatorMux1Control = 1'($urandom); comparatorMux2Control = 1'($urandom);
            rf_write = 1'($urandom);
            loadAddr = ($urandom_range(0, 2) == 0) ? {1'b0, ir_in[8:6]} : 4'($urandom);
            loadData = 16'($urandom);
            op = ir_in % 8; rdf = (ir_in / 8) % 8; r1 = (ir_in / 64) % 8;
            r2 = (ir_in / 512) % 8; fn = (ir_in / 4096) % 8; imm7 = ir_in / 512;
            simm = (imm7 >= 64) ? imm7 - 128 : imm7;
            comparatorMuxForward = ($urandom_range(0, 2) == 0) ? 16'(ref_read(r1)) : 16'($urandom);
            a = comparatorMux1Control ? ref_read(r1) : int'(comparatorMuxForward);
            b = comparatorMux2Control ? ref_read(rdf) : int'(comparatorMuxForward);
            sa = (a >= 32768) ? a - 65536 : a;
            sb = (b >= 32768) ? b - 65536 : b;
            taken = (op == 7) || (op == 4 && a == b) || (op == 5 && a != b) || (op == 6 && sa < sb);
            exp_pc = 16'(int'(pc_in) + 2 * simm);
            exp_imm = 16'(simm);
            case (op)
                0:       exp_ctrl = {1'b1, 1'b1, 3'(fn), 3'b001};
                1:       exp_ctrl = 8'b1_0_000_0_0_1;
                2:       exp_ctrl = 8'b1_0_000_0_1_0;
                3:       exp_ctrl = 8'b0_0_000_1_0_0;
                default: exp_ctrl = 8'b0_0_000_0_0_0;
            endcase
            #1;
            n_cmp++;
            if ({RegWrite, ALUSrc, ALUOp, MemWrite, MemRead, RegStore} !== exp_ctrl) begin
                n_err++; $display("FAIL rand_ctrl[%0d] ir=%h: got %b%b%b%b%b%b want %b", it, ir_in, RegWrite, ALUSrc, ALUOp, MemWrite, MemRead, RegStore, exp_ctrl);
            end
            n_cmp++;
            if ({Arg1, Arg2, Arg3} !== {16'(ref_read(r1)), 16'(ref_read(r2)), 16'(ref_read(rdf))}) begin
                n_err++; $display("FAIL rand_args[%0d] ir=%h: got %h %h %h want %h %h %h", it, ir_in, Arg1, Arg2, Arg3, 16'(ref_read(r1)), 16'(ref_read(r2)), 16'(ref_read(rdf)));
            end
            n_cmp++;
            if ({Imm, Rs1, Rs2, Rd} !== {exp_imm, 3'(r1), 3'(r2), 3'(rdf)}) begin
                n_err++; $display("FAIL rand_fields[%0d] ir=%h: got imm=%h %0d %0d %0d want %h %0d %0d %0d", it, ir_in, Imm, Rs1, Rs2, Rd, exp_imm, r1, r2, rdf);
            end
            n_cmp++;
            if ({new_pc, jump, OPCP2} !== {exp_pc, ~taken, IPCP2}) begin
                n_err++; $display("FAIL rand_branch[%0d] ir=%h: got pc=%h jump=%0b opcp2=%h want %h %0b %h", it, ir_in, new_pc, jump, OPCP2, exp_pc, ~taken, IPCP2);
            end
            step();
        end
        rf_write = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rf_write();
        test_rtype();
        test_itype_mem();
        test_branch();
        test_same_addr_and_x0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage of the 16-bit pipelined core.
- Contains the register file: 16 x 16-bit, written from the writeback stage.
- Cracks the fetched instruction into control signals, register operands, sign-extended immediate and register indices.
- Resolves branches early with a forwarding-capable comparator, producing the target PC and a PC-source select.

Parameters:
- NREGS, 16, number of register-file entries; write address is 4 bits.
- XLEN, 16, datapath width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- IPCP2  in  16  PC+2 of the instruction being decoded.
- pc_in  in  16  PC of the instruction being decoded.
- ir_in  in  16  instruction word.
- loadAddr  in  4  register-file write address.
- loadData  in  16  register-file write data.
- rf_write  in  1  register-file write enable.
- comparatorMux1Control  in  1  comparator A select: 1 = rf[rs1], 0 = comparatorMuxForward.
- comparatorMux2Control  in  1  comparator B select: 1 = rf[ir[5:3]], 0 = comparatorMuxForward.
- comparatorMuxForward  in  16  forwarded value from later stages.
- RegWrite  out  1  instruction writes rd.
- ALUSrc  out  1  1 = ALU B operand is Arg2; 0 = Imm.
- ALUOp  out  3  ALU operation; 000 = add, 001 = sub.
- MemWrite  out  1  store.
- MemRead  out  1  load.
- RegStore  out  1  writeback source: 1 = ALU result, 0 = memory.
- OPCP2  out  16  IPCP2 passed through.
- Arg1  out  16  rf[rs1].
- Arg2  out  16  rf[rs2].
- Arg3  out  16  rf[rd] (store data).
- Imm  out  16  sign-extended ir[15:9].
- Rs1  out  3  ir[8:6].
- Rs2  out  3  ir[11:9].
- Rd  out  3  ir[5:3].
- new_pc  out  16  branch/jump target.
- jump  out  1  PC-source select: 1 = sequential (PC+2), 0 = take new_pc.

Behaviour:
- Instruction format:
  - opcode = ir[2:0]; rd = ir[5:3]; rs1 = ir[8:6]; rs2 = ir[11:9]; funct = ir[15:12]; imm7 = ir[15:9].
- Register file:
  - Write is synchronous on rising clk when rf_write = 1: rf[loadAddr] <= loadData.
  - Reads are combinational, address zero-extended from 3 bits.
  - Register 0 always reads 0; writes to it are discarded.
  - reset asynchronously clears all entries.
- All other outputs are combinational from ir_in, pc_in, IPCP2 and the RF. Zero latency; the downstream ID/EX register latches them.
- Decode by opcode:
  - 000 R-type: RegWrite=1, ALUSrc=1, ALUOp=funct[2:0], MemRead=0, MemWrite=0, RegStore=1.
  - 001 I-type: RegWrite=1, ALUSrc=0, ALUOp=000, RegStore=1.
  - 010 load: RegWrite=1, ALUSrc=0, ALUOp=000, MemRead=1, RegStore=0.
  - 011 store: RegWrite=0, MemWrite=1, ALUSrc=0, ALUOp=000, RegStore=0.
  - 100 beq, 101 bne, 110 blt (signed), 111 j: RegWrite=0, MemRead=0, MemWrite=0, ALUSrc=0, ALUOp=000, RegStore=0.
- Branch resolution:
  - new_pc = pc_in + (Imm << 1), with 16-bit wrap-around.
  - jump = 0 when:
    - opcode 111; or
    - beq and A == B; or
    - bne and A != B; or
    - blt and signed(A) < signed(B).
  - Otherwise jump = 1.
- Unselected fields are still decoded: Imm, Rs1, Rs2, Rd, Arg1–Arg3 are always driven.
- While reset = 1: RegWrite, MemWrite and MemRead are forced to 0, and jump is forced to 1.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read whose address equals loadAddr while rf_write = 1 (and address != 0) returns loadData in the same cycle. This covers Arg1–Arg3 and both comparator register inputs.
- Undefined: reads return the stored value; the new value becomes visible after the clock edge.

Decomposition:
- Package decode_pkg: opcode constants (OP_R, OP_I, OP_LD, OP_ST, OP_BEQ, OP_BNE, OP_BLT, OP_J), ALUOp codes, field bit positions.
- Sub-module decode_regfile: 16x16, 1 write port, 3 read ports, async reset, optional bypass.

Test Plan:
- Reset, then write rf[5]=16, rf[6]=10, rf[4]=0xFFF8 on successive clocks -> values stored.
- ir=0x1D60 (R sub x4=x6-x5) -> RegWrite=1, ALUSrc=1, ALUOp=001, MemRead=0, MemWrite=0, RegStore=1, Arg1=16, Arg2=10, Arg3=0xFFF8, Rs1=5, Rs2=6, Rd=4, OPCP2=IPCP2=4, jump=1.
- ir=0x1961 (I-type addi, imm 12) -> ALUSrc=0, ALUOp=000, Imm=12, RegWrite=1, RegStore=1, jump=1.
- ir=0x1562 (load) -> MemRead=1, RegStore=0, Imm=10, RegWrite=1. ir=0x1563 (store) -> MemWrite=1, RegWrite=0, Arg3=0xFFF8.
- beq rs1=5 vs field=5, pc_in=2, imm=-2 -> jump=0, new_pc=0xFFFE. Repeat with comparatorMux2Control=0, forward=17 -> jump=1.
- Write and read x0; write while reading the same address -> reads 0; same-address read returns old value unless RF_BYPASS_EN is defined.
